// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line engine: receives 48-bit host commands (CRC7 and
// end-bit checked) and, when asked, drives a 48-bit or 136-bit response
// back onto the shared CMD line.
module sd_card_cmd_responder (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_in,
  output logic         cmd_oe,
  output logic         cmd_out,
  output logic         rx_valid,
  output logic [5:0]   rx_index,
  output logic [31:0]  rx_arg,
  output logic         rx_crc_err,
  output logic         rx_end_err,
  input  logic         resp_req,
  input  logic         resp_long,
  input  logic [127:0] resp_data,
  output logic         resp_busy,
  output logic         resp_done,
  output logic         resp_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_SKIP,
    ST_WAIT_RESP,
    ST_PRE,
    ST_SEND
  } state_e;

  localparam logic [7:0] LAST_CMD_BIT    = 8'd47;
  localparam logic [7:0] LAST_LONG_BIT   = 8'd135;
  localparam logic [7:0] CRC_LAST_BIT    = 8'd39;
  localparam logic [7:0] CRC_FIELD_FIRST = 8'd40;
  localparam logic [7:0] CRC_FIELD_LAST  = 8'd46;
  localparam logic [6:0] WINDOW_LAST     = 7'd63;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  state_e         state_q, state_d;
  logic           cmd_in_r_q, cmd_in_r_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [6:0]     win_cnt_q, win_cnt_d;
  logic [6:0]     crc_q, crc_d;
  logic [47:0]    rx_sr_q, rx_sr_d;
  logic [135:0]   tx_sr_q, tx_sr_d;
  logic           long_q, long_d;
  logic           cmd_oe_q, cmd_oe_d;
  logic           cmd_out_q, cmd_out_d;
  logic           rx_valid_q, rx_valid_d;
  logic [5:0]     rx_index_q, rx_index_d;
  logic [31:0]    rx_arg_q, rx_arg_d;
  logic           rx_crc_err_q, rx_crc_err_d;
  logic           rx_end_err_q, rx_end_err_d;
  logic           resp_busy_q, resp_busy_d;
  logic           resp_done_q, resp_done_d;
  logic           resp_timeout_q, resp_timeout_d;
  logic           frame_err;

  // Only the long response format carries resp_data[127]'s neighbours; the
  // top bit itself never reaches the line.
  logic resp_data_unused;
  assign resp_data_unused = resp_data[127];

  // Next-state and next-output computation for the whole CMD engine.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    win_cnt_d      = win_cnt_q;
    crc_d          = crc_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    long_d         = long_q;
    cmd_oe_d       = cmd_oe_q;
    cmd_out_d      = cmd_out_q;
    rx_index_d     = rx_index_q;
    rx_arg_d       = rx_arg_q;
    rx_crc_err_d   = rx_crc_err_q;
    rx_end_err_d   = rx_end_err_q;
    resp_busy_d    = resp_busy_q;
    rx_valid_d     = 1'b0;
    resp_done_d    = 1'b0;
    resp_timeout_d = 1'b0;
    frame_err      = 1'b0;
    // Our own drive echoes back on the pad; present it as an idle line.
    cmd_in_r_d     = cmd_oe_q | cmd_in;

    case (state_q)
      ST_IDLE: begin
        if (!cmd_in_r_q) begin
          state_d   = ST_RECV;
          bit_cnt_d = 8'd1;
          rx_sr_d   = {47'd0, cmd_in_r_q};
          crc_d     = crc7_step(7'd0, cmd_in_r_q);
        end
      end

      ST_RECV: begin
        rx_sr_d = {rx_sr_q[46:0], cmd_in_r_q};
        if (bit_cnt_q <= CRC_LAST_BIT) begin
          crc_d = crc7_step(crc_q, cmd_in_r_q);
        end
        if (bit_cnt_q == 8'd1 && !cmd_in_r_q) begin
          // Card-to-host traffic from another card: let it pass.
          state_d   = ST_SKIP;
          bit_cnt_d = 8'd2;
        end else if (bit_cnt_q == LAST_CMD_BIT) begin
          rx_valid_d   = 1'b1;
          rx_index_d   = rx_sr_d[45:40];
          rx_arg_d     = rx_sr_d[39:8];
          rx_crc_err_d = (crc_q != rx_sr_d[7:1]);
          rx_end_err_d = !cmd_in_r_q;
          frame_err    = (crc_q != rx_sr_d[7:1]) || !cmd_in_r_q;
          bit_cnt_d    = 8'd0;
          win_cnt_d    = 7'd0;
          state_d      = frame_err ? ST_IDLE : ST_WAIT_RESP;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end

      ST_SKIP: begin
        if (bit_cnt_q == LAST_CMD_BIT) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 8'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end

      ST_WAIT_RESP: begin
        win_cnt_d = win_cnt_q + 7'd1;
        if (!cmd_in_r_q) begin
          // Host gave up waiting and started a new command.
          state_d   = ST_RECV;
          bit_cnt_d = 8'd1;
          rx_sr_d   = {47'd0, cmd_in_r_q};
          crc_d     = crc7_step(7'd0, cmd_in_r_q);
        end else if (resp_req) begin
          state_d     = ST_PRE;
          long_d      = resp_long;
          tx_sr_d     = resp_long ? {2'b00, 6'h3F, resp_data[126:0], 1'b1}
                                  : {2'b00, resp_data[37:0], 7'd0, 1'b1, 88'd0};
          crc_d       = 7'd0;
          bit_cnt_d   = 8'd0;
          cmd_oe_d    = 1'b1;
          cmd_out_d   = 1'b1;
          resp_busy_d = 1'b1;
        end else if (win_cnt_q == WINDOW_LAST) begin
          state_d        = ST_IDLE;
          resp_timeout_d = 1'b1;
        end
      end

      ST_PRE: begin
        // Put the start bit on the line for the first SEND cycle.
        state_d   = ST_SEND;
        bit_cnt_d = 8'd0;
        cmd_out_d = tx_sr_q[135];
        tx_sr_d   = {tx_sr_q[134:0], 1'b0};
        if (!long_q) begin
          crc_d = crc7_step(crc_q, tx_sr_q[135]);
        end
      end

      ST_SEND: begin
        if (bit_cnt_q == (long_q ? LAST_LONG_BIT : LAST_CMD_BIT)) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = 8'd0;
          cmd_oe_d    = 1'b0;
          cmd_out_d   = 1'b1;
          resp_busy_d = 1'b0;
          resp_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          tx_sr_d   = {tx_sr_q[134:0], 1'b0};
          if (!long_q && bit_cnt_d >= CRC_FIELD_FIRST && bit_cnt_d <= CRC_FIELD_LAST) begin
            cmd_out_d = crc_q[6];
            crc_d     = {crc_q[5:0], 1'b0};
          end else begin
            cmd_out_d = tx_sr_q[135];
            if (!long_q && bit_cnt_d <= CRC_LAST_BIT) begin
              crc_d = crc7_step(crc_q, tx_sr_q[135]);
            end
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cmd_oe_d  = 1'b0;
        cmd_out_d = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs; reset releases the pad at once.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cmd_in_r_q     <= 1'b1;
      bit_cnt_q      <= 8'd0;
      win_cnt_q      <= 7'd0;
      crc_q          <= 7'd0;
      rx_sr_q        <= 48'd0;
      tx_sr_q        <= 136'd0;
      long_q         <= 1'b0;
      cmd_oe_q       <= 1'b0;
      cmd_out_q      <= 1'b1;
      rx_valid_q     <= 1'b0;
      rx_index_q     <= 6'd0;
      rx_arg_q       <= 32'd0;
      rx_crc_err_q   <= 1'b0;
      rx_end_err_q   <= 1'b0;
      resp_busy_q    <= 1'b0;
      resp_done_q    <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q        <= state_d;
      cmd_in_r_q     <= cmd_in_r_d;
      bit_cnt_q      <= bit_cnt_d;
      win_cnt_q      <= win_cnt_d;
      crc_q          <= crc_d;
      rx_sr_q        <= rx_sr_d;
      tx_sr_q        <= tx_sr_d;
      long_q         <= long_d;
      cmd_oe_q       <= cmd_oe_d;
      cmd_out_q      <= cmd_out_d;
      rx_valid_q     <= rx_valid_d;
      rx_index_q     <= rx_index_d;
      rx_arg_q       <= rx_arg_d;
      rx_crc_err_q   <= rx_crc_err_d;
      rx_end_err_q   <= rx_end_err_d;
      resp_busy_q    <= resp_busy_d;
      resp_done_q    <= resp_done_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign cmd_oe       = cmd_oe_q;
  assign cmd_out      = cmd_out_q;
  assign rx_valid     = rx_valid_q;
  assign rx_index     = rx_index_q;
  assign rx_arg       = rx_arg_q;
  assign rx_crc_err   = rx_crc_err_q;
  assign rx_end_err   = rx_end_err_q;
  assign resp_busy    = resp_busy_q;
  assign resp_done    = resp_done_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Self-checking bench for sd_card_cmd_responder: host-side stimulus with a
// polynomial-division CRC7 model and an event monitor on the card outputs.
module tb_sd_card_cmd_responder;

  logic         sd_clk = 1'b0;
  logic         rst;
  logic         cmd_in;
  logic         resp_req;
  logic         resp_long;
  logic [127:0] resp_data;
  logic         cmd_oe, cmd_out, rx_valid, rx_crc_err, rx_end_err;
  logic [5:0]   rx_index;
  logic [31:0]  rx_arg;
  logic         resp_busy, resp_done, resp_timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  sd_card_cmd_responder dut (
    .sd_clk       (sd_clk),
    .rst          (rst),
    .cmd_in       (cmd_in),
    .cmd_oe       (cmd_oe),
    .cmd_out      (cmd_out),
    .rx_valid     (rx_valid),
    .rx_index     (rx_index),
    .rx_arg       (rx_arg),
    .rx_crc_err   (rx_crc_err),
    .rx_end_err   (rx_end_err),
    .resp_req     (resp_req),
    .resp_long    (resp_long),
    .resp_data    (resp_data),
    .resp_busy    (resp_busy),
    .resp_done    (resp_done),
    .resp_timeout (resp_timeout)
  );

  always #5 sd_clk = ~sd_clk;

  // ---------------- reference model ----------------
  // CRC7 as the remainder of msg(x) * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_of(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7_of(body), 1'b1};
  endfunction

  function automatic logic [47:0] short_resp(input logic [127:0] d);
    logic [39:0] body;
    body = {2'b00, d[37:0]};
    return {body, crc7_of(body), 1'b1};
  endfunction

  // ---------------- output monitor ----------------
  int          cyc = 0;
  int          rx_cnt = 0, to_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int          rx_cyc = 0, to_cyc = 0, done_cyc = 0, oe_rise_cyc = 0, busy_rise_cyc = 0;
  logic [5:0]  rx_idx_s;
  logic [31:0] rx_arg_s;
  logic        rx_crc_s, rx_end_s;
  logic        prev_oe = 1'b0, prev_busy = 1'b0;
  logic        oe_bits[$];

  always @(posedge sd_clk) begin
    #2;
    cyc++;
    if (rx_valid) begin
      rx_cnt++;
      rx_cyc   = cyc;
      rx_idx_s = rx_index;
      rx_arg_s = rx_arg;
      rx_crc_s = rx_crc_err;
      rx_end_s = rx_end_err;
    end
    if (resp_timeout) begin to_cnt++;   to_cyc   = cyc; end
    if (resp_done)    begin done_cnt++; done_cyc = cyc; end
    if (cmd_oe) begin
      if (!prev_oe) oe_rise_cyc = cyc;
      oe_bits.push_back(cmd_out);
    end
    if (resp_busy) begin
      if (!prev_busy) busy_rise_cyc = cyc;
      busy_cnt++;
    end
    prev_oe   = cmd_oe;
    prev_busy = resp_busy;
  end

  int b_rx, b_to, b_done, b_oe, b_busy;

  task automatic mark();
    b_rx   = rx_cnt;
    b_to   = to_cnt;
    b_done = done_cnt;
    b_oe   = oe_bits.size();
    b_busy = busy_cnt;
  endtask

  function automatic logic [255:0] oe_since(input int from);
    logic [255:0] v;
    v = '0;
    for (int i = from; i < oe_bits.size(); i++) v = {v[254:0], oe_bits[i]};
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sd_clk);
  endtask

  // Drives a frame MSB-first; resp_req is raised during frame bit req_bit.
  task automatic drive_frame(input logic [47:0] f, input int req_bit);
    for (int b = 0; b < 48; b++) begin
      cmd_in   = f[47 - b];
      resp_req = (b == req_bit);
      @(negedge sd_clk);
    end
    cmd_in   = 1'b1;
    resp_req = 1'b0;
  endtask

  task automatic pulse_req(input logic lng, input logic [127:0] d);
    resp_req  = 1'b1;
    resp_long = lng;
    resp_data = d;
    @(negedge sd_clk);
    resp_req  = 1'b0;
    resp_long = 1'($urandom);
    resp_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + randomized sequence ----------------
  initial begin
    logic [47:0]  f, f2;
    logic [127:0] d;
    logic [136:0] lf;
    logic [255:0] obs;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         exp_crc_err;
    int           dly, req_cyc, pos, n;

    rst = 1'b1; cmd_in = 1'b1; resp_req = 1'b0; resp_long = 1'b0; resp_data = '0;
    idle(3);
    check("reset.cmd_oe",   cmd_oe, 0);
    check("reset.cmd_out",  cmd_out, 1);
    check("reset.rx_valid", rx_valid, 0);
    check("reset.rx_index", rx_index, 0);
    check("reset.rx_arg",   rx_arg, 0);
    check("reset.flags",    {resp_busy, resp_done, resp_timeout, rx_crc_err, rx_end_err}, 0);
    rst = 1'b0;
    idle(2);

    // CMD0, no response requested: window closes after 64 cycles.
    mark();
    drive_frame(48'h40_0000_0000_95, -1);
    idle(1);
    check("cmd0.rx_cnt",  rx_cnt - b_rx, 1);
    check("cmd0.index",   rx_idx_s, 0);
    check("cmd0.arg",     rx_arg_s, 0);
    check("cmd0.errs",    {rx_crc_s, rx_end_s}, 0);
    idle(70);
    check("cmd0.timeout_cnt", to_cnt - b_to, 1);
    check("cmd0.timeout_lat", to_cyc - rx_cyc, 64);
    check("cmd0.no_oe",       oe_bits.size() - b_oe, 0);

    // CMD8 first, then random commands (some corrupted) with short responses.
    for (int it = 0; it < 8; it++) begin
      idx = (it == 0) ? 6'd8 : 6'($urandom);
      arg = (it == 0) ? 32'h1AA : $urandom;
      f = make_cmd(idx, arg);
      if (it > 0 && $urandom_range(0, 2) == 0) begin
        pos = 8 + int'($urandom_range(0, 31));
        f[pos] = ~f[pos];
      end
      exp_crc_err = (crc7_of(f[47:8]) != f[7:1]);
      mark();
      drive_frame(f, -1);
      idle(1);
      check($sformatf("s%0d.rx_cnt", it), rx_cnt - b_rx, 1);
      check($sformatf("s%0d.index", it), rx_idx_s, f[45:40]);
      check($sformatf("s%0d.arg", it), rx_arg_s, f[39:8]);
      check($sformatf("s%0d.crc_err", it), rx_crc_s, exp_crc_err);
      check($sformatf("s%0d.end_err", it), rx_end_s, 0);
      dly = $urandom_range(0, 50);
      idle(dly);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (it == 0) d[37:0] = {6'd8, 32'h1AA};
      req_cyc = cyc;
      pulse_req(1'b0, d);
      idle(55);
      n = oe_bits.size() - b_oe;
      if (exp_crc_err) begin
        check($sformatf("s%0d.bad_no_oe", it), n, 0);
        check($sformatf("s%0d.bad_no_busy", it), busy_cnt - b_busy, 0);
        check($sformatf("s%0d.bad_no_timeout", it), to_cnt - b_to, 0);
      end else begin
        check($sformatf("s%0d.oe_len", it), n, 49);
        check($sformatf("s%0d.oe_rise", it), oe_rise_cyc - req_cyc, 1);
        check($sformatf("s%0d.bits", it), oe_since(b_oe), 256'({1'b1, short_resp(d)}));
        check($sformatf("s%0d.done_cnt", it), done_cnt - b_done, 1);
        check($sformatf("s%0d.done_lat", it), done_cyc - req_cyc, 50);
        check($sformatf("s%0d.busy_len", it), busy_cnt - b_busy, 49);
        check($sformatf("s%0d.busy_rise", it), busy_rise_cyc - req_cyc, 1);
        check($sformatf("s%0d.no_timeout", it), to_cnt - b_to, 0);
      end
      check($sformatf("s%0d.oe_low", it), {cmd_oe, cmd_out}, 2'b01);
      check($sformatf("s%0d.index_held", it), rx_index, f[45:40]);
    end

    // CMD8 with CRC byte 0x85: flagged, then an immediate resp_req is ignored.
    mark();
    drive_frame(48'h48_0000_01AA_85, -1);
    idle(1);
    check("badcrc.crc_err", rx_crc_s, 1);
    check("badcrc.end_err", rx_end_s, 0);
    pulse_req(1'b0, 128'h2_0000_01AA);
    idle(80);
    check("badcrc.no_oe",      oe_bits.size() - b_oe, 0);
    check("badcrc.no_busy",    busy_cnt - b_busy, 0);
    check("badcrc.no_timeout", to_cnt - b_to, 0);

    // End bit 0 with a good CRC.
    f = make_cmd(6'($urandom), $urandom);
    f[0] = 1'b0;
    mark();
    drive_frame(f, -1);
    idle(1);
    check("endbit.errs", {rx_crc_s, rx_end_s}, 2'b01);
    idle(80);
    check("endbit.no_timeout", to_cnt - b_to, 0);

    // Frame with transmission bit 0 is skipped; a command right behind it decodes.
    f = {2'b00, 46'({$urandom, $urandom})};
    f2 = make_cmd(6'd17, $urandom);
    mark();
    drive_frame(f, -1);
    drive_frame(f2, -1);
    idle(1);
    check("skip.rx_cnt", rx_cnt - b_rx, 1);
    check("skip.index",  rx_idx_s, 17);
    check("skip.arg",    rx_arg_s, f2[39:8]);
    idle(70);

    // Long R2 response; host line wiggles mid-send and must be ignored.
    d = 128'h1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0;
    lf = {1'b1, 2'b00, 6'h3F, d[126:0], 1'b1};
    mark();
    drive_frame(make_cmd(6'd2, $urandom), -1);
    idle(6);
    req_cyc = cyc;
    pulse_req(1'b1, d);
    idle(10);
    cmd_in = 1'b0;
    idle(12);
    cmd_in = 1'b1;
    idle(140);
    n = oe_bits.size() - b_oe;
    obs = oe_since(b_oe);
    check("long.oe_len",    n, 137);
    check("long.bits",      obs, 256'(lf));
    check("long.bits2_7",   obs[133:128], 6'h3F);
    check("long.end_bit",   obs[0], 1);
    check("long.busy_len",  busy_cnt - b_busy, 137);
    check("long.done_lat",  done_cyc - req_cyc, 138);
    check("long.rx_ignored", rx_cnt - b_rx, 1);
    check("long.no_timeout", to_cnt - b_to, 0);

    // Reset at bit 20 of a short response, then CMD0 decodes normally.
    d = {$urandom, $urandom, $urandom, $urandom};
    f = short_resp(d);
    drive_frame(make_cmd(6'd3, $urandom), -1);
    idle(1);
    pulse_req(1'b0, d);
    idle(21);
    check("rstmid.driving", {cmd_oe, cmd_out}, {1'b1, f[47 - 20]});
    rst = 1'b1;
    #1;
    check("rstmid.oe",     {cmd_oe, cmd_out}, 2'b01);
    check("rstmid.clears", {resp_busy, rx_index, rx_arg}, 0);
    idle(2);
    rst = 1'b0;
    idle(2);
    mark();
    drive_frame(48'h40_0000_0000_95, -1);
    idle(1);
    check("rstmid.cmd0_rx",   rx_cnt - b_rx, 1);
    check("rstmid.cmd0_flds", {rx_idx_s, rx_arg_s, rx_crc_s, rx_end_s}, 0);
    idle(70);

    // New command starts during the window, resp_req in the same cycle.
    f  = make_cmd(6'($urandom), $urandom);
    f2 = make_cmd(6'($urandom), $urandom);
    mark();
    drive_frame(f, -1);
    idle(1 + int'($urandom_range(2, 40)));
    drive_frame(f2, 1);
    idle(1);
    check("restart.rx_cnt",     rx_cnt - b_rx, 2);
    check("restart.index",      rx_idx_s, f2[45:40]);
    check("restart.arg",        rx_arg_s, f2[39:8]);
    check("restart.no_oe",      oe_bits.size() - b_oe, 0);
    check("restart.no_timeout", to_cnt - b_to, 0);
    idle(70);
    check("restart.second_window", to_cnt - b_to, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sd_card_cmd_responder.md
SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 SHALL have the following ports, one per line: name  direction  width  meaning.
REQ-002 sd_clk  in  1  SD clock; all sequential logic on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cmd_in  in  1  CMD line sampled from the pad; registered once before any use (cmd_in_r).
REQ-005 cmd_oe  out  1  CMD pad output enable; 1 only while the block drives a response.
REQ-006 cmd_out  out  1  CMD pad output value; idles at 1.
REQ-007 rx_valid  out  1  one-cycle pulse: a 48-bit command frame has been received.
REQ-008 rx_index  out  6  received command index, valid at rx_valid and held until the next rx_valid.
REQ-009 rx_arg  out  32  received argument, with the same hold rule as rx_index.
REQ-010 rx_crc_err  out  1  received CRC7 mismatch, qualified by rx_valid.
REQ-011 rx_end_err  out  1  received end bit is 0, qualified by rx_valid.
REQ-012 resp_req  in  1  one-cycle request to send a response; honoured only in WAIT_RESP.
REQ-013 resp_long  in  1  sampled with resp_req: 0 = 48-bit response, 1 = 136-bit R2 response.
REQ-014 resp_data  in  128  sampled with resp_req; short response uses [37:0] ({index, arg}); long response uses [126:0].
REQ-015 resp_busy  out  1  1 from the cycle after an accepted resp_req until the end bit has been driven.
REQ-016 resp_done  out  1  one-cycle pulse in the cycle cmd_oe falls after a response.
REQ-017 resp_timeout  out  1  one-cycle pulse when the response window closes unused.

Function
REQ-018 SHALL implement the states IDLE, RECV, SKIP, WAIT_RESP, PRE, SEND.
REQ-019 IDLE: cmd_in_r=0 -> RECV with bit counter = 1.
REQ-020 RECV: shift cmd_in_r MSB-first into a 48-bit register; the counter increments each cycle.
REQ-021 RECV bit 1 (transmission bit) = 0 -> SKIP. SKIP consumes the remaining frame bits up to bit 47, then -> IDLE with no rx_valid.
REQ-022 CRC7 (polynomial x^7+x^3+1, initial value 0) SHALL be computed serially over frame bits 0..39 and compared with frame bits 40..46.
REQ-023 After bit 47: rx_valid=1 for one cycle; rx_index = frame[45:40], rx_arg = frame[39:8], and the error flags are updated.
REQ-024 Error-free frame -> WAIT_RESP with the window counter cleared; any error -> IDLE (card never responds to a bad frame).
REQ-025 WAIT_RESP: the window counter increments each cycle. If it reaches 64 -> IDLE and resp_timeout pulses.
REQ-026 WAIT_RESP, cmd_in_r=0 -> RECV (the host started a new command) with no resp_timeout; a resp_req in that same cycle is ignored.
REQ-027 WAIT_RESP, resp_req=1 -> PRE, and resp_long and resp_data are latched.
REQ-028 resp_req in any state other than WAIT_RESP SHALL be ignored, with no side effects.
REQ-029 PRE (one cycle): cmd_oe=1, cmd_out=1.
REQ-030 SEND transmits MSB-first, one bit per cycle, with the first (start) bit on cmd_out two cycles after the resp_req cycle.
REQ-031 Short response frame: 0, 0, resp_data[37:0], CRC7 over the preceding 40 bits, 1; 48 bits total.
REQ-032 Long response frame: 0, 0, 6'b111111, resp_data[126:0], 1; 136 bits total; no internal CRC is generated.
REQ-033 The cycle after the end bit: cmd_oe=0, cmd_out=1, resp_done pulses, resp_busy=0, state -> IDLE.
REQ-034 cmd_in SHALL be ignored while cmd_oe=1.
REQ-035 The bit counter SHALL be 8 bits wide (maximum value 135) and the window counter 7 bits wide; neither counter wraps.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 rst=1 SHALL immediately force cmd_oe=0 and cmd_out=1, including in the middle of SEND.
REQ-038 rst=1 SHALL clear rx_valid, rx_crc_err, rx_end_err, resp_busy, resp_done and resp_timeout, and set rx_index=0 and rx_arg=0.
REQ-039 rst=1 SHALL set the state to IDLE and clear the shift register, the CRC and both counters.
REQ-040 The first start bit SHALL be accepted two cycles after rst deasserts.

Verification
REQ-041 Drive CMD0 frame 0x40_00000000_95 -> rx_valid with index 0, arg 0, both error flags 0; no resp_req -> resp_timeout exactly 64 cycles after the rx_valid-cycle transition.
REQ-042 Drive CMD8 frame 0x48_000001AA_87, then resp_req with long=0 and data[37:0] = {6'd8, 32'h1AA} -> cmd_out shows 1 then 0 (start bit) two cycles after resp_req; 48 bits whose CRC7 matches the bench model; resp_done pulse; cmd_oe low afterwards.
REQ-043 Drive CMD8 with its CRC byte corrupted to 0x85 -> rx_crc_err=1 and state IDLE; a resp_req issued immediately afterwards produces no cmd_oe activity.
REQ-044 Long response with data = 127'h1234...: exactly 136 bits driven; bits 2..7 are 1; the last bit is 1; resp_busy stays high for 137 cycles.
REQ-045 Assert rst at bit 20 of a SEND -> cmd_oe=0 immediately; a following CMD0 frame is received correctly.
REQ-046 Issue a new start bit during WAIT_RESP, with a simultaneous resp_req -> no response is sent, the new frame is decoded, and no resp_timeout is reported.
